mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single backing-memory port between the I-side (fetch) and D-side (load/store) cache-miss paths.
//  Grants one requester at a time, holds the grant until the memory acks, returns data and a one-cycle ack.
//  D-side has priority (older instruction in the pipe); a streak counter stops D-side from starving fetch.
//  Sits between the two cache controllers and the memory model; its acks release the caches' pipeline stalls.
// PARAMETERS
//  ADDR_WIDTH    32   byte-address width on all ports
//  DATA_WIDTH    128  transfer width (one cache line)
//  D_STREAK_MAX  4    max consecutive D grants while i_req is pending; must be >=1
// PORTS
//  clk        in   1           single clock, rising edge
//  reset      in   1           asynchronous, active-high
//  i_req      in   1           fetch miss request; held with i_addr stable until i_ack
//  i_addr     in   ADDR_WIDTH  fetch line address
//  i_ack      out  1           one-cycle pulse: i_rdata valid
//  i_rdata    out  DATA_WIDTH  fetched line
//  d_req      in   1           data request; held with d_we/d_addr/d_wdata stable until d_ack
//  d_we       in   1           1 = write (writeback), 0 = read (refill)
//  d_addr     in   ADDR_WIDTH  data line address
//  d_wdata    in   DATA_WIDTH  writeback line
//  d_ack      out  1           one-cycle pulse: write done / d_rdata valid
//  d_rdata    out  DATA_WIDTH  refill line
//  mem_req    out  1           memory request, held high until mem_ack
//  mem_we     out  1           memory write enable
//  mem_addr   out  ADDR_WIDTH  memory address
//  mem_wdata  out  DATA_WIDTH  memory write data
//  mem_ack    in   1           one-cycle pulse from memory: done / mem_rdata valid
//  mem_rdata  in   DATA_WIDTH  memory read data
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, streak=0; mem_req, mem_we, i_ack, d_ack = 0; addr/data regs = 0.
//  - FSM states: IDLE, SERVE_I, SERVE_D, RESP. All outputs registered.
//  - IDLE: d_req & !(i_req & streak==D_STREAK_MAX) -> SERVE_D; else i_req -> SERVE_I; else stay.
//    On the transition latch the winner's addr/we/wdata into mem_* regs and set mem_req=1 (visible next cycle).
//    I grants force mem_we=0.
//  - Streak: D grant with i_req high -> streak+1 (saturating); I grant, or i_req low in IDLE -> streak=0.
//  - SERVE_x: mem_req/mem_we/mem_addr/mem_wdata held stable; wait any number of cycles for mem_ack.
//    On mem_ack: mem_req<=0, mem_we<=0, latch mem_rdata into owner's rdata reg, pulse owner's ack next cycle -> RESP.
//  - RESP: exactly one cycle, ack high; no new grant; -> IDLE. Gives requester a cycle to drop req.
//  - Latency: req seen in IDLE at t -> mem_req at t+1; mem_ack at k -> ack at k+1; earliest next grant at k+2.
//  - i_rdata/d_rdata hold last value until overwritten; only valid with their ack. Non-owner ack never pulses.
//  - Request dropped while in SERVE_x: protocol violation; transaction still completes and acks.
//  - mem_ack in IDLE/RESP: ignored. Reset mid-transaction: abandoned, no ack; memory model must drop it.
// STRUCTURE
//  - defines.v: state encodings `ARB_IDLE, `ARB_SERVE_I, `ARB_SERVE_D, `ARB_RESP (2-bit).
//  - No sub-module; single FSM + streak counter + output regs.
// TESTING
//  1 Single fetch: i_req, i_addr=0x100, mem_ack 3 cycles after mem_req, mem_rdata=0xA5.. -> mem_addr=0x100,
//    mem_we=0, i_ack one cycle, i_rdata=0xA5.., d_ack never high.
//  2 Simultaneous: i_req & d_req at same edge, d_we=1, d_addr=0x200 -> D served first (mem_we=1), then I;
//    exactly one ack each, mem_req never overlaps, RESP gap of one cycle between transactions.
//  3 Starvation: d_req held (re-raised after each ack) and i_req held, D_STREAK_MAX=4 -> grants D,D,D,D,I,D...
//  4 Long latency: mem_ack after 50 cycles -> mem_addr/mem_wdata stable for all 50 cycles, ack at ack+1.
//  5 Reset mid-op: reset asserted in SERVE_D between edges -> mem_req drops immediately, no d_ack,
//    state IDLE and streak 0 after release; fresh i_req served normally.
//  6 Spurious mem_ack in IDLE with no requests -> no ack pulses, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM encoding and default sizing shared by the memory arbiter and its interface
package mem_arbiter_pkg;
    localparam int ARB_ADDR_WIDTH   = 32;
    localparam int ARB_DATA_WIDTH   = 128;
    localparam int ARB_D_STREAK_MAX = 4;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-port signals around the arbiter; slave is the arbiter's view
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data misses; D wins unless it has starved fetch
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
    parameter int D_STREAK_MAX = ARB_D_STREAK_MAX
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(D_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);
    arb_state_e            r_state, w_next;
    logic [SW-1:0]         r_streak, w_streak;
    logic                  w_idle, w_serving, w_grant_d, w_grant_i, w_done;
    logic                  r_mem_req, r_mem_we, r_i_ack, r_d_ack;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata, r_i_rdata, r_d_rdata;
    always_comb begin
        w_idle    = r_state == IDLE;
        w_serving = r_state == SERVE_I || r_state == SERVE_D;
        w_grant_d = w_idle && bus.d_req && !(bus.i_req && r_streak == STREAK_MAX);
        w_grant_i = w_idle && !w_grant_d && bus.i_req;
        w_done    = w_serving && bus.mem_ack;
        w_next    = w_grant_d ? SERVE_D :
                    w_grant_i ? SERVE_I :
                    w_done    ? RESP    :
                    (r_state == RESP) ? IDLE : r_state;
        // streak only counts D wins that made a waiting fetch wait longer
        w_streak  = !w_idle                  ? r_streak :
                    !(w_grant_d && bus.i_req) ? '0       :
                    (r_streak == STREAK_MAX)  ? r_streak : r_streak + SW'(1);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_next;
            r_streak <= w_streak;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_i_ack <= w_done && r_state == SERVE_I;
            r_d_ack <= w_done && r_state == SERVE_D;
            if (w_grant_d || w_grant_i) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_grant_d && bus.d_we;
                r_mem_addr  <= w_grant_d ? bus.d_addr : bus.i_addr;
                r_mem_wdata <= w_grant_d ? bus.d_wdata : '0;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end
            if (w_done && r_state == SERVE_I) r_i_rdata <= bus.mem_rdata;
            if (w_done && r_state == SERVE_D) r_d_rdata <= bus.mem_rdata;
        end
    end
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_ack     = r_i_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
endmodule
